// File: rtl/sqwave_meter_if.sv
// Result bundle of the square-wave meter: measured input plus m/n codes.
// master = meter side, slave = stimulus/consumer side.
interface sqwave_meter_if #(
  parameter int CNT_W = 4
);
  logic             in;
  logic [CNT_W-1:0] m_meas;
  logic [CNT_W-1:0] n_meas;
  logic             valid;
  logic             stuck;

  modport master (
    input  in,
    output m_meas,
    output n_meas,
    output valid,
    output stuck
  );

  modport slave (
    output in,
    input  m_meas,
    input  n_meas,
    input  valid,
    input  stuck
  );
endinterface

// File: rtl/sqwave_meter.sv
// Measures high/low phases of a square wave in TICK_DIV-clock units.
// Ports: clk, rst_n (async low), bus (in -> m_meas/n_meas/valid/stuck).
module sqwave_meter #(
  parameter int TICK_DIV = 5,
  parameter int CNT_W    = 4
) (
  input logic           clk,
  input logic           rst_n,
  sqwave_meter_if.master bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW:0] P_HALF = (PW+1)'(TICK_DIV / 2);
  localparam logic [PW:0] P_DIV = (PW+1)'(TICK_DIV);
  localparam logic [CNT_W-1:0] MAXC = '1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } state_e;

  state_e state_q, state_d;

  logic in_s1_q, in_s1_d;
  logic in_s_q, in_s_d;
  logic in_d_q, in_d_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CNT_W:0] unit_q, unit_d;
  logic hi_ok_q, hi_ok_d;
  logic [CNT_W-1:0] hi_code_q, hi_code_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic valid_q, valid_d;
  logic stuck_q, stuck_d;

  logic edge_w;
  logic timeout;
  logic [PW:0] rnd_sum;
  logic rnd_up;
  logic [CNT_W+1:0] code_raw;
  logic [CNT_W-1:0] code;

  assign in_s1_d = bus.in;
  assign in_s_d  = in_s1_q;
  assign in_d_d  = in_s_q;
  assign edge_w  = in_s_q ^ in_d_q;
  // Unit counter freezes at 2^CNT_W, so its top bit is the timeout.
  assign timeout = unit_q[CNT_W];

  // Counters hold the raw phase length c (unit*DIV + presc);
  // rounding to nearest unit is applied only when a code is taken.
  always_comb begin
    rnd_sum  = {1'b0, presc_q} + P_HALF;
    rnd_up   = (rnd_sum >= P_DIV);
    code_raw = {1'b0, unit_q}
             + {{(CNT_W+1){1'b0}}, rnd_up};
    code     = (code_raw > {2'b00, MAXC})
             ? MAXC : code_raw[CNT_W-1:0];
  end

  // The edge cycle itself is the first clock of the new phase.
  always_comb begin
    presc_d = presc_q;
    unit_d  = unit_q;
    if (edge_w) begin
      presc_d = PW'(1);
      unit_d  = '0;
    end else if (!timeout) begin
      if (presc_q == P_LAST) begin
        presc_d = '0;
        unit_d  = unit_q + (CNT_W+1)'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_ok_d   = hi_ok_q;
    hi_code_d = hi_code_q;
    m_d       = m_q;
    n_d       = n_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    unique case (state_q)
      IDLE: begin
        if (edge_w) begin
          state_d = in_s_q ? HIGH : LOW;
          hi_ok_d = 1'b0;
        end
      end
      HIGH, LOW: begin
        if (edge_w) begin
          if (state_q == HIGH) begin
            hi_code_d = code;
            hi_ok_d   = 1'b1;
            state_d   = LOW;
          end else begin
            if (hi_ok_q) begin
              m_d     = hi_code_q;
              n_d     = code;
              valid_d = 1'b1;
            end
            state_d = HIGH;
          end
        end else if (timeout) begin
          state_d = STUCK;
          valid_d = 1'b1;
          stuck_d = 1'b1;
          m_d     = in_s_q ? MAXC : '0;
          n_d     = in_s_q ? '0 : MAXC;
        end
      end
      STUCK: begin
        // The partial phase that ends here is never reported.
        if (edge_w) begin
          stuck_d = 1'b0;
          hi_ok_d = 1'b0;
          state_d = in_s_q ? HIGH : LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_s1_q   <= 1'b0;
      in_s_q    <= 1'b0;
      in_d_q    <= 1'b0;
      presc_q   <= '0;
      unit_q    <= '0;
      hi_ok_q   <= 1'b0;
      hi_code_q <= '0;
      m_q       <= '0;
      n_q       <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_s1_q   <= in_s1_d;
      in_s_q    <= in_s_d;
      in_d_q    <= in_d_d;
      presc_q   <= presc_d;
      unit_q    <= unit_d;
      hi_ok_q   <= hi_ok_d;
      hi_code_q <= hi_code_d;
      m_q       <= m_d;
      n_q       <= n_d;
      valid_q   <= valid_d;
      stuck_q   <= stuck_d;
    end
  end

  assign bus.m_meas = m_q;
  assign bus.n_meas = n_q;
  assign bus.valid  = valid_q;
  assign bus.stuck  = stuck_q;
endmodule

// File: tb/tb_sqwave_meter.sv
// Randomized bench for sqwave_meter with an edge-time reference model.
// Drives in on negedge, checks outputs on negedge every cycle.
module tb_sqwave_meter;
  localparam int D    = 5;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;
  localparam int TO   = (1 << W) * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sqwave_meter_if #(.CNT_W(W)) bus ();

  sqwave_meter #(
    .TICK_DIV(D),
    .CNT_W(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: reports keyed by the clock index where they must appear.
  typedef enum int { M_IDLE, M_HIGH, M_LOW, M_STUCK } mode_e;
  mode_e mode;
  bit    prev_lvl;
  int    last_edge;
  bit    hi_ok;
  int    hi_len_code;
  int    rep_m[int];
  int    rep_n[int];
  int    st_ev[int];
  int    cur_m, cur_n, cur_st;
  bit    lv;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d want %0d", tag, cyc, got, want);
    end
  endtask

  function automatic int to_code(input int len);
    int c;
    c = (len + D / 2) / D;
    return (c > MAXC) ? MAXC : c;
  endfunction

  task automatic model_reset();
    mode = M_IDLE;
    prev_lvl = 1'b0;
    last_edge = 0;
    hi_ok = 1'b0;
    hi_len_code = 0;
    cur_m = 0;
    cur_n = 0;
    cur_st = 0;
    rep_m.delete();
    rep_n.delete();
    st_ev.delete();
  endtask

  // k: clock index whose rising edge first samples level v.
  // Any report it causes is visible after clock k+2.
  task automatic model_step(input bit v, input int k);
    int code;
    if (v != prev_lvl) begin
      code = to_code(k - last_edge);
      case (mode)
        M_IDLE: begin
          mode = v ? M_HIGH : M_LOW;
          hi_ok = 1'b0;
        end
        M_STUCK: begin
          st_ev[k+2] = 0;
          mode = v ? M_HIGH : M_LOW;
          hi_ok = 1'b0;
        end
        M_HIGH: begin
          hi_len_code = code;
          hi_ok = 1'b1;
          mode = M_LOW;
        end
        default: begin
          if (hi_ok) begin
            rep_m[k+2] = hi_len_code;
            rep_n[k+2] = code;
          end
          mode = M_HIGH;
        end
      endcase
      last_edge = k;
      prev_lvl = v;
    end else if ((mode == M_HIGH || mode == M_LOW)
                 && (k - last_edge == TO)) begin
      rep_m[k+2] = v ? MAXC : 0;
      rep_n[k+2] = v ? 0 : MAXC;
      st_ev[k+2] = 1;
      mode = M_STUCK;
    end
  endtask

  task automatic check_cycle();
    int ev;
    ev = 0;
    if (rep_m.exists(cyc)) begin
      cur_m = rep_m[cyc];
      cur_n = rep_n[cyc];
      ev = 1;
    end
    if (st_ev.exists(cyc)) cur_st = st_ev[cyc];
    chk("valid", int'(bus.valid), ev);
    chk("m_meas", int'(bus.m_meas), cur_m);
    chk("n_meas", int'(bus.n_meas), cur_n);
    chk("stuck", int'(bus.stuck), cur_st);
  endtask

  task automatic step(input bit v);
    @(negedge clk);
    check_cycle();
    bus.in = v;
    model_step(v, cyc + 1);
  endtask

  task automatic phase(input bit v, input int len);
    lv = v;
    repeat (len) step(v);
  endtask

  task automatic pat(input int hi, input int lo, input int reps);
    repeat (reps) begin
      phase(1'b1, hi);
      phase(1'b0, lo);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m"}, int'(bus.m_meas), 0);
    chk({tag, "_n"}, int'(bus.n_meas), 0);
    chk({tag, "_valid"}, int'(bus.valid), 0);
    chk({tag, "_stuck"}, int'(bus.stuck), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_cycle();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_now");
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    model_reset();
    model_step(bus.in, cyc + 1);
  endtask

  initial begin
    bus.in = 1'b0;
    lv = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    model_step(bus.in, cyc + 1);

    pat(5, 10, 6);
    phase(1'b1, 5);
    phase(1'b0, 4);
    do_reset();
    phase(1'b0, 6);
    pat(5, 10, 3);

    pat(15, 10, 3);
    pat(25, 25, 3);

    phase(1'b1, 100);
    pat(10, 10, 3);
    phase(1'b1, 5);
    phase(1'b0, 100);
    pat(10, 10, 3);

    pat(7, 8, 3);
    pat(2, 13, 3);
    pat(74, 5, 3);

    lv = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int len;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 4);
      else len = $urandom_range(5, 95);
      phase(!lv, len);
    end
    phase(lv, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sqwave_meter.md
Name: sqwave_meter

Overview:
Downstream companion to the programmable square-wave generator. Consumes the generator's single-bit output and measures each high phase and low phase in 100 ns units (5 clocks at 50 MHz). Reports the results as m_meas/n_meas with a one-cycle valid strobe. The codes use the same m/n encoding that drives the generator, so closed-loop self-check benches can compare them directly.

Parameters:
TICK_DIV, 5, clocks per measurement unit (100 ns at 50 MHz); legal range is 2 or more.
CNT_W, 4, width of m_meas/n_meas; maximum code MAXC = 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in  input  1  square wave to measure; asynchronous to clk is allowed.
m_meas  output  CNT_W  last measured high time, in units.
n_meas  output  CNT_W  last measured low time, in units.
valid  output  1  one-cycle pulse when m_meas/n_meas update.
stuck  output  1  high while the input has had no edge for 2^CNT_W units.

Behaviour:
- Reset (async, rst_n=0): all flops clear; m_meas=0, n_meas=0, valid=0, stuck=0; state goes to IDLE. Reset asserted mid-measurement discards all partial counts.
- Input path: 2-flop synchronizer (in_s1 -> in_s), then a delay flop in_d. An edge is in_s != in_d. Rising edge: in_s=1. Falling edge: in_s=0.
- Phase length L: clocks from one edge cycle to the next edge cycle.
- Measured code: floor((L + TICK_DIV/2)/TICK_DIV), using integer TICK_DIV/2, saturating at MAXC.
  - Exact multiples of TICK_DIV measure exactly; 5 clocks -> 1, 15 clocks -> 3.
- Counters: a prescaler (0..TICK_DIV-1) and a unit counter (CNT_W+1 bits) both restart on every edge cycle.
- States:
  - IDLE: wait for the first edge; the phase before it is unknown. Rising edge -> HIGH. Falling edge -> LOW with hi_ok=0.
  - HIGH: on a falling edge, latch hi_code, set hi_ok=1, go to LOW.
  - LOW: on a rising edge, latch lo_code.
    - If hi_ok=1: next cycle m_meas<=hi_code, n_meas<=lo_code, valid=1 for one cycle.
    - Go to HIGH.
  - STUCK: entered from HIGH or LOW (not IDLE) when the unit counter reaches 2^CNT_W with no edge.
    - On entry: valid=1 for one cycle, stuck=1.
    - If in_s=1: m_meas=MAXC, n_meas=0. If in_s=0: m_meas=0, n_meas=MAXC.
    - Any edge: stuck<=0, no valid; go to HIGH (rising) or LOW (falling with hi_ok=0). The partial phase is never reported.
- Latency: valid is high on the 3rd rising clk edge after the first edge that samples the new input level of the completing rising transition.
- Simultaneous events: a timeout and an edge in the same cycle resolve as the edge (no STUCK entry).
- Glitch/short phases:
  - A phase of L < TICK_DIV/2 clocks yields code 0 and is reported as is.
  - Pulses narrower than 1 clock may be missed; this is documented, not flagged.
- m_meas/n_meas hold their value between valid strobes.

Test Plan:
- Reset mid-stream: in toggling, pulse rst_n low 1 cycle -> outputs 0 immediately; the first valid appears only after a full high+low cycle completes after reset.
- Generator pattern m=1,n=2 (high 5 clk, low 10 clk, repeating) -> first valid after the second rising edge with m_meas=1, n_meas=2; valid repeats every 15 clocks, each strobe exactly 1 cycle wide.
- Pattern 3/2 then switch to 5/5 -> reports 3/2 until the first complete 5/5 cycle, then 5/5. No mixed 3/5 or 5/2 report is allowed unless the switch falls exactly between phases.
- Static high (generator m=1,n=0) for 100 clocks after toggling -> at 80 clocks without an edge: valid pulse, stuck=1, m_meas=15, n_meas=0. Static low -> m_meas=0, n_meas=15.
- Rounding: high 7 clk/low 8 clk -> m_meas=1, n_meas=2. High 2 clk/low 13 clk -> m_meas=0, n_meas=3. High 74 clk/low 5 clk -> m_meas=15 (saturated), n_meas=1, stuck stays 0.
- Recovery: from STUCK apply 2/2 -> stuck clears on the first edge; the first valid is 2/2, with no report of the stuck-phase length.
